vga_sync_decoder: RTL

- Receive-side counterpart of the VGA timing driver. Samples the Hsync, Vsync, VGA_en and 12-bit RGB bus that the driver produces.
- Recovers pixel coordinates and emits a pixel stream. Measures line and frame geometry and flags any timing violations.
- Two uses: as a frame-capture front end, and as the on-chip or bench monitor proving the display path meets 640x480@60Hz timing.

---
 rtl/vga_sync_decoder.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: receive-side VGA timing checker and pixel recoverer.
// Samples Hsync/Vsync/VGA_en/RGB, rebuilds (x,y) coordinates, emits a pixel
// stream two clocks after the input, measures line/frame geometry and raises
// sticky error flags when the timing deviates from the parameters.
// Ports:
//   clk, rst_n                  pixel clock, synchronous active-low reset
//   Hsync, Vsync                active-low syncs from the timing driver
//   VGA_en, vgaRed/Green/Blue   active-video qualifier and 12-bit colour
//   err_clr                     pulse that clears err_flags
//   pix_valid, pix_x, pix_y     recovered pixel stream with coordinates
//   pix_data                    {R,G,B}, zero when pix_valid is low
//   frame_done                  one-cycle pulse at each frame start
//   h_period, v_period          last measured clocks/line and lines/frame
//   locked                      timing matches all parameters
//   err_flags                   sticky: h_period, hsync width, active width,
//                               v_period/vsync width, active height
module vga_sync_decoder #(
  parameter int unsigned H_TOTAL = 800,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_DISP  = 640,
  parameter int unsigned V_TOTAL = 525,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_DISP  = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Hsync,
  input  logic        Vsync,
  input  logic        VGA_en,
  input  logic [3:0]  vgaRed,
  input  logic [3:0]  vgaGreen,
  input  logic [3:0]  vgaBlue,
  input  logic        err_clr,
  output logic        pix_valid,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic [11:0] pix_data,
  output logic        frame_done,
  output logic [10:0] h_period,
  output logic [10:0] v_period,
  output logic        locked,
  output logic [4:0]  err_flags
);

  localparam int unsigned CW = 11;
  localparam int unsigned DW = 12;
  localparam int unsigned EW = 5;
  localparam logic [CW-1:0] CMAX = '1;

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

  state_t state, state_nxt;

  // Input stage and previous-sample registers
  logic          hs1, vs1, en1, clr1;
  logic [DW-1:0] rgb1;
  logic          hs1_d, vs1_d, en1_d;

  // Measurement counters
  logic [CW-1:0] hcnt, lcnt, hsw, vsw, xcnt, alines;
  logic          armed, full, frame_err;

  logic          hf, hr, vf, vr, en_fall, live, any_err;
  logic [CW-1:0] x_now, hp_new, vp_new;
  logic [EW-1:0] new_err;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CMAX) ? v : v + CW'(1);
  endfunction

  // Edge detection on the registered syncs
  always_comb begin
    hf      = hs1_d & ~hs1;
    hr      = ~hs1_d & hs1;
    vf      = vs1_d & ~vs1;
    vr      = ~vs1_d & vs1;
    en_fall = en1_d & ~en1;
    live    = (state != SEARCH);
    x_now   = hf ? '0 : xcnt;
    hp_new  = sat_inc(hcnt);
    vp_new  = sat_inc(lcnt);
  end

  // Timing checks; line checks need a line start seen while tracking,
  // frame checks need one complete frame observed first
  always_comb begin
    new_err = '0;
    if (live) begin
      new_err[0] = full && hf && (hp_new != CW'(H_TOTAL));
      new_err[1] = armed && hr && (hsw != CW'(H_SYNC));
      new_err[2] = armed && en_fall && (xcnt != CW'(H_DISP));
      // Vsync width shares the vertical-period flag
      new_err[3] = (full && vf && (vp_new != CW'(V_TOTAL))) ||
                   (armed && vr && (vsw != CW'(V_SYNC)));
      new_err[4] = full && vf && (alines != CW'(V_DISP));
    end
    any_err = |new_err;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= SEARCH;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH: if (vf) state_nxt = ALIGN;
      ALIGN:  if (vf && full && !frame_err && !any_err) state_nxt = LOCKED;
      LOCKED: if (any_err) state_nxt = ALIGN;
      default: state_nxt = SEARCH;
    endcase
  end

  // Input stage, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs1        <= 1'b1;
      vs1        <= 1'b1;
      en1        <= 1'b0;
      clr1       <= 1'b0;
      rgb1       <= '0;
      hs1_d      <= 1'b1;
      vs1_d      <= 1'b1;
      en1_d      <= 1'b0;
      hcnt       <= '0;
      lcnt       <= '0;
      hsw        <= '0;
      vsw        <= '0;
      xcnt       <= '0;
      alines     <= '0;
      armed      <= 1'b0;
      full       <= 1'b0;
      frame_err  <= 1'b0;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_data   <= '0;
      frame_done <= 1'b0;
      h_period   <= '0;
      v_period   <= '0;
      locked     <= 1'b0;
      err_flags  <= '0;
    end else begin
      hs1   <= Hsync;
      vs1   <= Vsync;
      en1   <= VGA_en;
      clr1  <= err_clr;
      rgb1  <= {vgaRed, vgaGreen, vgaBlue};
      hs1_d <= hs1;
      vs1_d <= vs1;
      en1_d <= en1;

      if (hf) begin
        h_period <= hp_new;
        hcnt     <= '0;
      end else begin
        hcnt <= sat_inc(hcnt);
      end

      hsw  <= hs1 ? '0 : sat_inc(hsw);
      vsw  <= vs1 ? '0 : (hf ? sat_inc(vsw) : vsw);
      xcnt <= en1 ? sat_inc(x_now) : x_now;

      if (vf) begin
        v_period <= vp_new;
        lcnt     <= '0;
        alines   <= '0;
      end else begin
        if (hf)      lcnt   <= sat_inc(lcnt);
        if (en_fall) alines <= sat_inc(alines);
      end

      // Tracking qualifiers are dropped while searching
      if (!live) begin
        armed     <= vf && hf;
        full      <= 1'b0;
        frame_err <= 1'b0;
      end else begin
        if (hf) armed <= 1'b1;
        if (vf) full <= 1'b1;
        if (vf)           frame_err <= 1'b0;
        else if (any_err) frame_err <= 1'b1;
      end

      pix_valid <= live && en1;
      pix_data  <= (live && en1) ? rgb1 : '0;
      if (live && en1) begin
        pix_x <= x_now;
        pix_y <= alines;
      end

      frame_done <= vf;
      locked     <= (state_nxt == LOCKED);
      // Set wins over a simultaneous clear
      err_flags  <= (err_flags & ~{EW{clr1}}) | new_err;
    end
  end

endmodule
